// File: rtl/if_prefetch_queue_pkg.sv
// if_prefetch_queue_pkg: shared state encoding and reset fetch address
package if_prefetch_queue_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
endpackage

// File: rtl/if_prefetch_queue_if.sv
// if_prefetch_queue_if: redirect, IF/ID and instruction memory signals of the prefetch queue
interface if_prefetch_queue_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pcplus4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  modport slave (
    input  redirect, redirect_pc, inst_ready, imem_ack, imem_rdata,
    output inst_valid, inst, inst_pc, inst_pcplus4, imem_req, imem_addr
  );
  modport master (
    output redirect, redirect_pc, inst_ready, imem_ack, imem_rdata,
    input  inst_valid, inst, inst_pc, inst_pcplus4, imem_req, imem_addr
  );
endinterface

// File: rtl/if_prefetch_queue_pf_fifo.sv
// pf_fifo: synchronous FIFO of {pc, inst} entries with clear and simultaneous push/pop at any fill level
module pf_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_clear,
  input  logic [63:0]   i_din,
  output logic [AW:0]   o_count,
  output logic [63:0]   o_head
);
  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  // storage is reset too so the head reads as zero straight out of reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_mem[r_wptr] <= i_din;
      r_wptr  <= r_wptr + AW'(i_push);
      r_rptr  <= r_rptr + AW'(i_pop);
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];
endmodule

// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: owns the fetch PC, requests words from imem and buffers them for IF/ID
module if_prefetch_queue
  import if_prefetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic               i_clk,
  input logic               i_rst_n,
  if_prefetch_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_req_addr;
  logic [31:0] w_fetch_next;
  logic [31:0] w_req_next;
  logic [31:0] w_target;
  logic [AW:0] w_count;
  logic [AW:0] w_count_next;
  logic [63:0] w_head;
  logic        w_push;
  logic        w_pop;
  logic        w_credit;
  assign w_target     = {bus.redirect_pc[31:2], 2'b00};
  assign w_pop        = bus.inst_valid & bus.inst_ready;
  assign w_push       = (r_state == WAIT) & bus.imem_ack & ~bus.redirect;
  assign w_count_next = w_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign w_credit     = w_count_next < (AW+1)'(DEPTH);
  always_comb begin
    w_state_next = r_state;
    w_fetch_next = r_fetch_pc;
    w_req_next   = r_req_addr;
    if (bus.redirect) begin
      if (r_state == IDLE || bus.imem_ack) begin
        w_state_next = WAIT;
        w_req_next   = w_target;
        w_fetch_next = w_target + 32'd4;
      end else begin
        w_state_next = DROP;
        w_fetch_next = w_target;
      end
    end else begin
      case (r_state)
        IDLE: if (w_credit) begin
          w_state_next = WAIT;
          w_req_next   = r_fetch_pc;
          w_fetch_next = r_fetch_pc + 32'd4;
        end
        WAIT: if (bus.imem_ack) begin
          w_state_next = w_credit ? WAIT : IDLE;
          w_req_next   = w_credit ? r_fetch_pc : r_req_addr;
          w_fetch_next = w_credit ? r_fetch_pc + 32'd4 : r_fetch_pc;
        end
        DROP: if (bus.imem_ack) begin
          w_state_next = WAIT;
          w_req_next   = r_fetch_pc;
          w_fetch_next = r_fetch_pc + 32'd4;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_next;
      r_req_addr <= w_req_next;
    end
  end
  pf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (bus.redirect),
    .i_din   ({r_req_addr, bus.imem_rdata}),
    .o_count (w_count),
    .o_head  (w_head)
  );
  assign bus.imem_req     = r_state != IDLE;
  assign bus.imem_addr    = r_req_addr;
  assign bus.inst_valid   = w_count != '0;
  assign bus.inst         = w_head[31:0];
  assign bus.inst_pc      = w_head[63:32];
  assign bus.inst_pcplus4 = w_head[63:32] + 32'd4;
endmodule
